branch_resolve_ctrl: RTL

Sequences updates to the 16-entry 1-bit branch prediction buffer and recovers the pipeline on mispredicts. Records every predicted branch leaving fetch in an in-order in-flight queue, matches each execute-stage resolution against its recorded prediction, and drives the buffer's update port (`En` / `Prev` / `PredActual`). On a mispredict it flushes younger work, redirects fetch and holds fetch for a fixed recovery window. Sits between fetch, execute and the branch predictor.

---
 rtl/branch_resolve_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: keeps an in-order queue of predicted branches,
// issues 1-bit predictor updates and recovers fetch after a mispredict.
module branch_resolve_ctrl #(
  parameter int DEPTH        = 4,
  parameter int PC_W         = 32,
  parameter int IDX_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Fetch_Valid,
  input  logic [0:IDX_W-1]       Fetch_Index,
  input  logic                   Fetch_Pred,
  input  logic [0:PC_W-1]        Fetch_Alt_PC,
  input  logic                   Resolve_Valid,
  input  logic                   Resolve_Taken,
  output logic                   Upd_En,
  output logic [0:IDX_W-1]       Upd_Index,
  output logic [0:1]             Upd_PredActual,
  output logic                   Flush,
  output logic                   Redirect_Valid,
  output logic [0:PC_W-1]        Redirect_PC,
  output logic                   Stall_Fetch,
  output logic [0:$clog2(DEPTH)] Inflight_Count,
  output logic                   Err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL       = CNT_W'(DEPTH);
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [3:0]         flush_cnt_q, flush_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               upd_en_q, upd_en_d;
  logic [IDX_W-1:0]   upd_index_q, upd_index_d;
  logic [1:0]         upd_pa_q, upd_pa_d;
  logic               recover_q, recover_d;
  logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;

  logic [IDX_W-1:0]   idx_mem  [DEPTH];
  logic               pred_mem [DEPTH];
  logic [PC_W-1:0]    alt_mem  [DEPTH];

  logic               stall;
  logic               push, pop, mispredict, resolve_run, mem_we;
  logic [IDX_W-1:0]   head_idx;
  logic               head_pred;
  logic [PC_W-1:0]    head_alt;

  assign head_idx    = idx_mem[rd_ptr_q];
  assign head_pred   = pred_mem[rd_ptr_q];
  assign head_alt    = alt_mem[rd_ptr_q];
  assign resolve_run = Resolve_Valid && (state_q == S_RUN);
  assign pop         = resolve_run && (count_q != '0);
  assign mispredict  = pop && (head_pred != Resolve_Taken);
  assign push        = Fetch_Valid && !stall;
  // A push coinciding with a mispredict belongs to the squashed path.
  assign mem_we      = push && !mispredict;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_RUN: begin
        if (mispredict) begin
          state_d     = S_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) state_d = S_RUN;
        else                   flush_cnt_d = flush_cnt_q - 4'd1;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    stall = (count_q == FULL) || (state_q == S_FLUSH);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mispredict) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    err_d         = err_q || (resolve_run && (count_q == '0));
    upd_en_d      = pop;
    upd_index_d   = pop ? head_idx : upd_index_q;
    upd_pa_d      = pop ? {head_pred, Resolve_Taken} : upd_pa_q;
    recover_d     = mispredict;
    redirect_pc_d = mispredict ? head_alt : redirect_pc_q;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      upd_en_q      <= 1'b0;
      upd_index_q   <= '0;
      upd_pa_q      <= '0;
      recover_q     <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_q         <= err_d;
      upd_en_q      <= upd_en_d;
      upd_index_q   <= upd_index_d;
      upd_pa_q      <= upd_pa_d;
      recover_q     <= recover_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      idx_mem[wr_ptr_q]  <= Fetch_Index;
      pred_mem[wr_ptr_q] <= Fetch_Pred;
      alt_mem[wr_ptr_q]  <= Fetch_Alt_PC;
    end
  end

  assign Upd_En         = upd_en_q;
  assign Upd_Index      = upd_index_q;
  assign Upd_PredActual = upd_pa_q;
  assign Flush          = recover_q;
  assign Redirect_Valid = recover_q;
  assign Redirect_PC    = redirect_pc_q;
  assign Stall_Fetch    = stall;
  assign Inflight_Count = count_q;
  assign Err            = err_q;

endmodule
